// File: rtl/trigger_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trigger_conditioner                                                        |
// | Synchronises, debounces and holds off a raw trigger for the monostable;    |
// | emits a clean level, edge strobes and a saturating rejected-glitch count.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module trigger_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int HOLDOFF_CYCLES  = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       raw_in,
  input  logic       glitch_clr,
  output logic       trigger,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic       busy,
  output logic [7:0] glitch_count
);

  localparam int MAX_CYC = (DEBOUNCE_CYCLES > HOLDOFF_CYCLES) ? DEBOUNCE_CYCLES : HOLDOFF_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Entry into a qualifying state is sample #1, so the last compare value is N-2.
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  localparam logic [2:0] IDLE_LOW  = 3'd0;
  localparam logic [2:0] QUAL_HIGH = 3'd1;
  localparam logic [2:0] HIGH      = 3'd2;
  localparam logic [2:0] QUAL_LOW  = 3'd3;
  localparam logic [2:0] HOLDOFF   = 3'd4;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   glitch_ev;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [7:0]             gcnt_q, gcnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // State register plus the registered strobes and glitch counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      gcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      gcnt_q  <= gcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    glitch_ev = 1'b0;
    case (state_q)
      IDLE_LOW: begin
        if (enable && s) state_d = QUAL_HIGH;
      end
      QUAL_HIGH: begin
        if (!enable) begin
          state_d = IDLE_LOW;
        end else if (!s) begin
          state_d   = IDLE_LOW;
          glitch_ev = 1'b1;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (!enable)  state_d = HOLDOFF;
        else if (!s)  state_d = QUAL_LOW;
      end
      QUAL_LOW: begin
        if (!enable) begin
          state_d = HOLDOFF;
        end else if (s) begin
          state_d   = HIGH;
          glitch_ev = 1'b1;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HOLDOFF;
        end
      end
      HOLDOFF: begin
        // A level held through holdoff must still be fully requalified.
        if (cnt_q == HOLD_LAST) state_d = (enable && s) ? QUAL_HIGH : IDLE_LOW;
      end
      default: state_d = IDLE_LOW;
    endcase
  end

  always_comb begin
    trigger = (state_q == HIGH) || (state_q == QUAL_LOW);
    busy    = (state_q != IDLE_LOW);
    rise_d  = (state_q == QUAL_HIGH) && (state_d == HIGH);
    fall_d  = (state_q != HOLDOFF) && (state_d == HOLDOFF);

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == QUAL_HIGH) || (state_q == QUAL_LOW) || (state_q == HOLDOFF)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end

    if (glitch_clr) begin
      gcnt_d = 8'd0;
    end else if (glitch_ev && (gcnt_q != 8'hFF)) begin
      gcnt_d = gcnt_q + 8'd1;
    end else begin
      gcnt_d = gcnt_q;
    end
  end

  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign glitch_count = gcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_trigger_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_trigger_conditioner                                                     |
// | Directed self-checking bench (SYNC=2, DEBOUNCE=4, HOLDOFF=8).              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_trigger_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       raw_in;
  logic       glitch_clr;
  logic       trigger;
  logic       rise_pulse;
  logic       fall_pulse;
  logic       busy;
  logic [7:0] glitch_count;

  int checks   = 0;
  int failures = 0;

  trigger_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .HOLDOFF_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .raw_in      (raw_in),
    .glitch_clr  (glitch_clr),
    .trigger     (trigger),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .busy        (busy),
    .glitch_count(glitch_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; raw_in = 1'b1; glitch_clr = 1'b0;

    // Reset with raw_in high, then release and qualify the held level
    tick(3);
    chk("rst_trigger", trigger, 0);
    chk("rst_rise", rise_pulse, 0);
    chk("rst_fall", fall_pulse, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gcnt", glitch_count, 0);
    rst_n = 1'b1;
    tick(5);
    chk("rel_trig_e5", trigger, 0);
    chk("rel_busy_e5", busy, 1);
    tick(1);
    chk("rel_trig_e6", trigger, 1);
    chk("rel_rise_e6", rise_pulse, 1);
    chk("rel_gcnt", glitch_count, 0);
    tick(1);
    chk("rel_rise_e7", rise_pulse, 0);

    // Release from HIGH, bouncing through the holdoff window
    raw_in = 1'b0;
    tick(4);
    chk("fall_trig_e4", trigger, 1);
    chk("fall_busy_e4", busy, 1);
    raw_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("bnc_trigger", trigger, (i == 0) ? 1 : 0);
      chk("bnc_fall", fall_pulse, (i == 1) ? 1 : 0);
      chk("bnc_rise", rise_pulse, 0);
      chk("bnc_busy", busy, 1);
      chk("bnc_gcnt", glitch_count, 0);
      raw_in = ~raw_in;
    end
    raw_in = 1'b0;
    tick(1);
    chk("hold_busy_e13", busy, 1);
    tick(1);
    chk("hold_busy_e14", busy, 0);
    tick(3);
    chk("post_hold_busy", busy, 0);
    chk("post_hold_gcnt", glitch_count, 0);

    // Clean press
    raw_in = 1'b1;
    tick(2);
    chk("press_busy_e2", busy, 0);
    tick(1);
    chk("press_busy_e3", busy, 1);
    tick(2);
    chk("press_trig_e5", trigger, 0);
    tick(1);
    chk("press_trig_e6", trigger, 1);
    chk("press_rise_e6", rise_pulse, 1);
    chk("press_fall_e6", fall_pulse, 0);
    tick(1);
    chk("press_rise_e7", rise_pulse, 0);
    chk("press_trig_e7", trigger, 1);

    raw_in = 1'b0;
    tick(16);
    chk("idle_busy", busy, 0);
    chk("idle_trig", trigger, 0);

    // Short pulse rejected as a glitch
    raw_in = 1'b1;
    tick(3);
    raw_in = 1'b0;
    tick(2);
    chk("gl_busy_e5", busy, 1);
    chk("gl_gcnt_e5", glitch_count, 0);
    tick(1);
    chk("gl_busy_e6", busy, 0);
    chk("gl_trig_e6", trigger, 0);
    chk("gl_gcnt_e6", glitch_count, 1);

    // 300 back-to-back glitches saturate the counter
    for (int g = 0; g < 300; g++) begin
      raw_in = 1'b1;
      tick(2);
      raw_in = 1'b0;
      tick(1);
    end
    tick(3);
    chk("sat_gcnt", glitch_count, 255);
    chk("sat_busy", busy, 0);
    chk("sat_trig", trigger, 0);

    // Clear coincident with a glitch event: clear wins
    raw_in = 1'b1;
    tick(2);
    raw_in = 1'b0;
    tick(2);
    chk("clr_pre_busy", busy, 1);
    chk("clr_pre_gcnt", glitch_count, 255);
    glitch_clr = 1'b1;
    tick(1);
    glitch_clr = 1'b0;
    chk("clr_gcnt", glitch_count, 0);
    chk("clr_busy", busy, 0);
    raw_in = 1'b1;
    tick(2);
    raw_in = 1'b0;
    tick(3);
    chk("clr_recount", glitch_count, 1);

    // Disable while HIGH forces a release and a full holdoff
    raw_in = 1'b1;
    tick(6);
    chk("dis_trig_high", trigger, 1);
    tick(1);
    enable = 1'b0;
    tick(1);
    chk("dis_trig", trigger, 0);
    chk("dis_fall", fall_pulse, 1);
    chk("dis_rise", rise_pulse, 0);
    chk("dis_busy", busy, 1);
    tick(1);
    chk("dis_fall_off", fall_pulse, 0);
    tick(6);
    chk("dis_busy_e7", busy, 1);
    tick(1);
    chk("dis_busy_e8", busy, 0);
    tick(2);
    chk("dis_idle_busy", busy, 0);
    chk("dis_idle_trig", trigger, 0);
    enable = 1'b1;
    tick(1);
    chk("en_busy", busy, 1);
    tick(2);
    chk("en_trig_pre", trigger, 0);
    tick(1);
    chk("en_trig", trigger, 1);
    chk("en_rise", rise_pulse, 1);

    // Reset in the middle of holdoff
    enable = 1'b0;
    tick(1);
    chk("dis2_fall", fall_pulse, 1);
    tick(3);
    chk("dis2_busy", busy, 1);
    rst_n = 1'b0;
    tick(1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_trig", trigger, 0);
    chk("rst_mid_fall", fall_pulse, 0);
    chk("rst_mid_gcnt", glitch_count, 0);

    // Disable during QUAL_HIGH returns to idle without counting a glitch
    enable = 1'b1;
    rst_n  = 1'b1;
    tick(3);
    chk("qh_busy", busy, 1);
    enable = 1'b0;
    tick(1);
    chk("qh_dis_busy", busy, 0);
    chk("qh_dis_gcnt", glitch_count, 0);
    tick(4);
    chk("qh_dis_trig", trigger, 0);
    chk("qh_dis_busy2", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
